// File: rtl/alu_exec_unit.sv
// Execute stage: ALUOp/funct decode, single-cycle integer ops, and iterative
// multiply/divide into HI/LO behind a valid/ready handshake.
module alu_exec_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter bit          EXT_OPS = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [1:0]               ALUOp,
    input  logic [5:0]               funct,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic [3:0]               alu_control,
    output logic [WIDTH-1:0]         result_o,
    output logic                     zero_o,
    output logic                     done_o,
    output logic                     illegal_o,
    output logic [WIDTH-1:0]         hi_o,
    output logic [WIDTH-1:0]         lo_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t state, state_nx;

    logic               illegal, muldiv, ext, accept;
    logic [3:0]         ctl;
    logic [WIDTH-1:0]   res;
    logic [WIDTH-1:0]   abs_a, abs_b;

    logic               op_div, neg_q, neg_r, bzero;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand, prod, prod_fix;
    logic [WIDTH-1:0]   mplier, rem, quo, dvsr, q_fix, r_fix;
    logic [WIDTH+1:0]   trial;

    // Decode: extended codes are tagged and demoted to illegal when EXT_OPS is off
    always_comb begin
        ctl     = 4'b0000;
        ext     = 1'b0;
        illegal = 1'b0;
        muldiv  = 1'b0;
        unique case (ALUOp)
            2'b00: ctl = 4'b0010;
            2'b01: ctl = 4'b0110;
            2'b10: begin
                unique case (funct)
                    6'b100000: ctl = 4'b0010;
                    6'b100010: ctl = 4'b0110;
                    6'b100100: ctl = 4'b0000;
                    6'b100101: ctl = 4'b0001;
                    6'b101010: ctl = 4'b0111;
                    6'b100110: begin ctl = 4'b0011; ext = 1'b1; end
                    6'b100111: begin ctl = 4'b1100; ext = 1'b1; end
                    6'b000000: begin ctl = 4'b1000; ext = 1'b1; end
                    6'b000010: begin ctl = 4'b1001; ext = 1'b1; end
                    6'b000011: begin ctl = 4'b1010; ext = 1'b1; end
                    6'b101011: begin ctl = 4'b1011; ext = 1'b1; end
                    6'b010000: begin ctl = 4'b1110; ext = 1'b1; end
                    6'b010010: begin ctl = 4'b1111; ext = 1'b1; end
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                        ctl    = 4'b1101;
                        ext    = 1'b1;
                        muldiv = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (ext && !EXT_OPS) begin
            ctl     = 4'b0000;
            illegal = 1'b1;
            muldiv  = 1'b0;
        end
        alu_control = ctl;
    end

    always_comb begin
        res = '0;
        unique case (ctl)
            4'b0010: res = a + b;
            4'b0110: res = a - b;
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0111: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b0011: res = a ^ b;
            4'b1100: res = ~(a | b);
            4'b1000: res = a << shamt;
            4'b1001: res = a >> shamt;
            4'b1010: res = $unsigned($signed(a) >>> shamt);
            4'b1011: res = {{(WIDTH-1){1'b0}}, (a < b)};
            4'b1110: res = hi_o;
            4'b1111: res = lo_o;
            default: res = '0;
        endcase
        if (illegal) res = '0;
    end

    assign ready_o = (state == IDLE);
    assign accept  = valid_i & ready_o;
    assign abs_a   = (a[WIDTH-1] && !funct[0]) ? -a : a;
    assign abs_b   = (b[WIDTH-1] && !funct[0]) ? -b : b;

    // Restoring step: shift next dividend bit into the partial remainder, try subtract
    assign trial    = {1'b0, rem, quo[WIDTH-1]} - {2'b00, dvsr};
    assign prod_fix = neg_q ? -prod : prod;
    assign q_fix    = bzero ? '1 : (neg_q ? -quo : quo);
    assign r_fix    = neg_r ? -rem : rem;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept && muldiv) state_nx = funct[1] ? DIV : MUL;
            MUL, DIV: if (cnt == CW'(WIDTH-1)) state_nx = FIX;
            FIX: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_o  <= '0;
            zero_o    <= 1'b1;
            done_o    <= 1'b0;
            illegal_o <= 1'b0;
            hi_o      <= '0;
            lo_o      <= '0;
            op_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            bzero     <= 1'b0;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
        end else begin
            done_o    <= 1'b0;
            illegal_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && muldiv) begin
                        op_div <= funct[1];
                        neg_q  <= !funct[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= !funct[0] && a[WIDTH-1];
                        bzero  <= (b == '0);
                        cnt    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, abs_a};
                        mplier <= abs_b;
                        prod   <= '0;
                        rem    <= '0;
                        quo    <= abs_a;
                        dvsr   <= abs_b;
                    end else if (accept) begin
                        result_o  <= res;
                        zero_o    <= (res == '0);
                        done_o    <= 1'b1;
                        illegal_o <= illegal;
                    end
                end
                MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                DIV: begin
                    if (trial[WIDTH+1]) begin
                        rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end else begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (op_div) begin
                        lo_o <= q_fix;
                        hi_o <= r_fix;
                    end else begin
                        {hi_o, lo_o} <= prod_fix;
                    end
                    done_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit at WIDTH=32 with extended ops enabled.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset, valid_i, ready_o;
    logic [1:0]  ALUOp;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] a, b, result_o, hi_o, lo_o;
    logic [3:0]  alu_control;
    logic        zero_o, done_o, illegal_o;

    int checks   = 0;
    int failures = 0;

    alu_exec_unit #(.WIDTH(32), .EXT_OPS(1'b1)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
        .ALUOp(ALUOp), .funct(funct), .shamt(shamt), .a(a), .b(b),
        .alu_control(alu_control), .result_o(result_o), .zero_o(zero_o),
        .done_o(done_o), .illegal_o(illegal_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] xa, input logic [31:0] xb);
        @(negedge clk);
        valid_i = 1'b1;
        ALUOp   = op;
        funct   = fn;
        shamt   = sh;
        a       = xa;
        b       = xb;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        a       = 32'hDEAD_BEEF;
        b       = 32'h1234_5678;
        funct   = 6'b100000;
    endtask

    // Counts busy samples from just after acceptance until ready_o returns
    task automatic wait_done(input string tag, input int exp_busy);
        int n = 0;
        while (!ready_o && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check({tag, " busy"}, 64'(n), 64'(exp_busy));
        check({tag, " done"}, {63'd0, done_o}, 64'd1);
    endtask

    task automatic alu(input string tag, input logic [1:0] op, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] exp);
        issue(op, fn, sh, xa, xb);
        check({tag, " res"}, {32'd0, result_o}, {32'd0, exp});
        check({tag, " zero"}, {63'd0, zero_o}, {63'd0, (exp == 32'd0)});
        check({tag, " done"}, {63'd0, done_o}, 64'd1);
    endtask

    task automatic decode(input string tag, input logic [1:0] op, input logic [5:0] fn,
                          input logic [3:0] exp);
        @(negedge clk);
        ALUOp = op;
        funct = fn;
        #1;
        check({tag, " ctl"}, {60'd0, alu_control}, {60'd0, exp});
    endtask

    initial begin
        int seen;
        reset   = 1'b1;
        valid_i = 1'b0;
        ALUOp   = 2'b00;
        funct   = 6'd0;
        shamt   = 5'd0;
        a       = 32'd0;
        b       = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst result", {32'd0, result_o}, 64'd0);
        check("rst zero", {63'd0, zero_o}, 64'd1);
        check("rst done", {63'd0, done_o}, 64'd0);
        check("rst illegal", {63'd0, illegal_o}, 64'd0);
        check("rst hilo", {hi_o, lo_o}, 64'd0);
        check("rst ready", {63'd0, ready_o}, 64'd1);
        @(negedge clk);
        reset = 1'b0;

        decode("dec sub", 2'b10, 6'b100010, 4'b0110);
        decode("dec ld", 2'b00, 6'b111111, 4'b0010);
        decode("dec beq", 2'b01, 6'b000000, 4'b0110);
        decode("dec div", 2'b10, 6'b011010, 4'b1101);
        decode("dec sra", 2'b10, 6'b000011, 4'b1010);
        decode("dec 11", 2'b11, 6'b100000, 4'b0000);

        alu("sub", 2'b10, 6'b100010, 5'd0, 32'd5, 32'd7, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;
        check("done pulse", {63'd0, done_o}, 64'd0);
        alu("add wrap", 2'b00, 6'b000000, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu("slt", 2'b10, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu("sltu", 2'b10, 6'b101011, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu("sra", 2'b10, 6'b000011, 5'd4, 32'h8000_0000, 32'd99, 32'hF800_0000);
        alu("srl", 2'b10, 6'b000010, 5'd4, 32'h8000_0000, 32'd99, 32'h0800_0000);
        alu("sll", 2'b10, 6'b000000, 5'd31, 32'd1, 32'd0, 32'h8000_0000);
        alu("and", 2'b10, 6'b100100, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        alu("or", 2'b10, 6'b100101, 5'd0, 32'hF0F0_F0F0, 32'h0F00_0000, 32'hFFF0_F0F0);
        alu("xor", 2'b10, 6'b100110, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        alu("nor", 2'b10, 6'b100111, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFF);

        issue(2'b10, 6'b011000, 5'd0, 32'hFFFF_FFFD, 32'd7);
        wait_done("mult", 33);
        check("mult hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
        check("mult held res", {32'd0, result_o}, 64'h0000_0000_FFFF_FFFF);

        issue(2'b10, 6'b011001, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu", 33);
        check("multu hilo", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);

        issue(2'b10, 6'b011010, 5'd0, 32'hFFFF_FFF9, 32'd2);
        wait_done("div", 33);
        check("div hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(2'b10, 6'b011011, 5'd0, 32'd9, 32'd0);
        wait_done("divu0", 33);
        check("divu0 hilo", {hi_o, lo_o}, 64'h0000_0009_FFFF_FFFF);
        alu("mfhi", 2'b10, 6'b010000, 5'd0, 32'd0, 32'd0, 32'd9);

        issue(2'b10, 6'b011010, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div ovf", 33);
        check("div ovf hilo", {hi_o, lo_o}, 64'h0000_0000_8000_0000);

        issue(2'b10, 6'b011010, 5'd0, 32'hFFFF_FFFB, 32'd0);
        wait_done("div0 s", 33);
        check("div0 s hilo", {hi_o, lo_o}, 64'hFFFF_FFFB_FFFF_FFFF);

        alu("add3", 2'b10, 6'b100000, 5'd0, 32'd1, 32'd2, 32'd3);
        issue(2'b10, 6'b011001, 5'd0, 32'd6, 32'd7);
        @(negedge clk);
        valid_i = 1'b1;
        ALUOp   = 2'b10;
        funct   = 6'b010010;
        repeat (3) @(posedge clk);
        #1;
        valid_i = 1'b0;
        wait_done("multu2", 30);
        check("mflo ignored", {32'd0, result_o}, 64'd3);
        check("multu2 hilo", {hi_o, lo_o}, 64'd42);
        alu("mflo", 2'b10, 6'b010010, 5'd0, 32'd0, 32'd0, 32'd42);

        issue(2'b11, 6'b100000, 5'd0, 32'd1, 32'd1);
        check("ill11 flag", {63'd0, illegal_o}, 64'd1);
        check("ill11 res", {32'd0, result_o}, 64'd0);
        check("ill11 zero", {63'd0, zero_o}, 64'd1);
        check("ill11 done", {63'd0, done_o}, 64'd1);
        check("ill11 hilo", {hi_o, lo_o}, 64'd42);
        issue(2'b10, 6'b111111, 5'd0, 32'd1, 32'd1);
        check("illfn flag", {63'd0, illegal_o}, 64'd1);
        check("illfn done", {63'd0, done_o}, 64'd1);
        issue(2'b10, 6'b100000, 5'd0, 32'd1, 32'd1);
        check("legal flag", {63'd0, illegal_o}, 64'd0);

        issue(2'b10, 6'b011011, 5'd0, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort ready", {63'd0, ready_o}, 64'd1);
        check("abort hilo", {hi_o, lo_o}, 64'd0);
        check("abort done", {63'd0, done_o}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_o) seen++;
        end
        check("abort no done", 64'(seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
